// File: rtl/fetch_decode_stage.sv
// Instruction fetch + field decode stage: owns the PC, fetches over req/ack, holds one word for control_unit.
// Optional illegal-opcode flag enabled by defining ILLEGAL_OPCODE_CHECK_EN.
module fetch_decode_stage #(
  parameter int unsigned          PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_ack,
  input  logic [31:0]         imem_rdata,
  input  logic                redirect_valid,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  output logic                instr_valid,
  input  logic                instr_ready,
  output logic [PC_WIDTH-1:0] pc_out,
  output logic [5:0]          opcode,
  output logic [9:0]          xox,
  output logic [8:0]          xoxo,
  output logic [1:0]          xods,
  output logic [4:0]          rs_rt,
  output logic [4:0]          ra,
  output logic [4:0]          rb,
  output logic [15:0]         imm16,
  output logic [23:0]         li,
  output logic [13:0]         bd,
  output logic                aa,
  output logic                lk_rc,
  output logic                oe,
  output logic                illegal_op
);

  typedef enum logic [1:0] {
    ST_REQ   = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic [PC_WIDTH-1:0]   addr_q, addr_d;
  logic [PC_WIDTH-1:0]   pc_out_q, pc_out_d;
  logic [31:0]           ir_q, ir_d;
  logic                  req_q, req_d;
  logic                  valid_q, valid_d;
  logic                  capture_c;

  // Next-state, PC and fetch-address logic; redirect overrides everything.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    addr_d    = addr_q;
    ir_d      = ir_q;
    pc_out_d  = pc_out_q;
    capture_c = 1'b0;

    unique case (state_q)
      ST_REQ: begin
        if (req_q && imem_ack) begin
          if (!redirect_valid) begin
            capture_c = 1'b1;
            ir_d      = imem_rdata;
            pc_out_d  = pc_q;
            pc_d      = pc_q + PC_WIDTH'(4);
            state_d   = ST_HOLD;
          end
        end else if (req_q && redirect_valid) begin
          // Request still outstanding: address must stay put until it is acked.
          state_d = ST_DRAIN;
        end
      end
      ST_HOLD: begin
        if (redirect_valid || instr_ready) state_d = ST_REQ;
      end
      ST_DRAIN: begin
        if (imem_ack) state_d = ST_REQ;
      end
      default: state_d = ST_REQ;
    endcase

    if (redirect_valid) pc_d = redirect_pc;
    if (state_d == ST_REQ) addr_d = pc_d;

    req_d   = (state_d != ST_HOLD);
    valid_d = (state_d == ST_HOLD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_REQ;
      pc_q     <= RESET_PC;
      addr_q   <= RESET_PC;
      pc_out_q <= '0;
      ir_q     <= '0;
      req_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      addr_q   <= addr_d;
      pc_out_q <= pc_out_d;
      ir_q     <= ir_d;
      req_q    <= req_d;
      valid_q  <= valid_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign instr_valid = valid_q;
  assign pc_out      = pc_out_q;

  assign opcode = ir_q[31:26];
  assign xox    = ir_q[10:1];
  assign xoxo   = ir_q[9:1];
  assign xods   = ir_q[1:0];
  assign rs_rt  = ir_q[25:21];
  assign ra     = ir_q[20:16];
  assign rb     = ir_q[15:11];
  assign imm16  = ir_q[15:0];
  assign li     = ir_q[25:2];
  assign bd     = ir_q[15:2];
  assign aa     = ir_q[1];
  assign lk_rc  = ir_q[0];
  assign oe     = ir_q[10];

`ifdef ILLEGAL_OPCODE_CHECK_EN
  logic illegal_q, illegal_d;
  logic rdata_illegal_c;

  // Opcode whitelist of the supported uPower subset.
  always_comb begin
    rdata_illegal_c = 1'b1;
    unique case (imem_rdata[31:26])
      6'd14, 6'd15, 6'd18, 6'd19, 6'd24, 6'd26, 6'd28, 6'd31, 6'd32,
      6'd34, 6'd36, 6'd37, 6'd38, 6'd40, 6'd42, 6'd44, 6'd58, 6'd62:
        rdata_illegal_c = 1'b0;
      default: rdata_illegal_c = 1'b1;
    endcase
  end

  always_comb begin
    illegal_d = 1'b0;
    if (capture_c)               illegal_d = rdata_illegal_c;
    else if (state_d == ST_HOLD) illegal_d = illegal_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) illegal_q <= 1'b0;
    else        illegal_q <= illegal_d;
  end

  assign illegal_op = illegal_q;
`else
  assign illegal_op = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_decode_stage.sv
// Directed bench for fetch_decode_stage: handshake timing, decode slices, redirects, PC wrap.
module tb_fetch_decode_stage;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] pc_out;
  logic [5:0]  opcode;
  logic [9:0]  xox;
  logic [8:0]  xoxo;
  logic [1:0]  xods;
  logic [4:0]  rs_rt;
  logic [4:0]  ra;
  logic [4:0]  rb;
  logic [15:0] imm16;
  logic [23:0] li;
  logic [13:0] bd;
  logic        aa;
  logic        lk_rc;
  logic        oe;
  logic        illegal_op;

  int tests;
  int fails;

`ifdef ILLEGAL_OPCODE_CHECK_EN
  localparam logic EXP_ILL = 1'b1;
`else
  localparam logic EXP_ILL = 1'b0;
`endif

  fetch_decode_stage #(.PC_WIDTH(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .pc_out(pc_out), .opcode(opcode), .xox(xox), .xoxo(xoxo), .xods(xods),
    .rs_rt(rs_rt), .ra(ra), .rb(rb), .imm16(imm16), .li(li), .bd(bd),
    .aa(aa), .lk_rc(lk_rc), .oe(oe), .illegal_op(illegal_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    imem_ack = 1'b0;
    imem_rdata = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    instr_ready = 1'b0;

    #1;
    chk("rst_req",     32'(imem_req), 32'd0);
    chk("rst_valid",   32'(instr_valid), 32'd0);
    chk("rst_pc_out",  pc_out, 32'd0);
    chk("rst_opcode",  32'(opcode), 32'd0);
    chk("rst_illegal", 32'(illegal_op), 32'd0);

    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk("rel_req",  32'(imem_req), 32'd1);
    chk("rel_addr", imem_addr, 32'h0);

    // add r1,r2,r3 with zero-wait ack
    imem_ack = 1'b1; imem_rdata = 32'h7C221A14; instr_ready = 1'b1;
    tick();
    imem_ack = 1'b0;
    chk("add_valid",  32'(instr_valid), 32'd1);
    chk("add_opcode", 32'(opcode), 32'd31);
    chk("add_rs",     32'(rs_rt), 32'd1);
    chk("add_ra",     32'(ra), 32'd2);
    chk("add_rb",     32'(rb), 32'd3);
    chk("add_xox",    32'(xox), 32'd266);
    chk("add_xoxo",   32'(xoxo), 32'd266);
    chk("add_oe",     32'(oe), 32'd0);
    chk("add_lkrc",   32'(lk_rc), 32'd0);
    chk("add_pc_out", pc_out, 32'h0);
    chk("add_req",    32'(imem_req), 32'd0);
    tick();
    chk("next_req",   32'(imem_req), 32'd1);
    chk("next_addr",  imem_addr, 32'h4);
    chk("next_valid", 32'(instr_valid), 32'd0);

    // ld r5,8(r1) with ack delayed 3 cycles
    instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("wait_req",  32'(imem_req), 32'd1);
      chk("wait_addr", imem_addr, 32'h4);
    end
    imem_ack = 1'b1; imem_rdata = 32'hE8A10008;
    tick();
    imem_ack = 1'b0;
    chk("ld_valid",  32'(instr_valid), 32'd1);
    chk("ld_opcode", 32'(opcode), 32'd58);
    chk("ld_rs",     32'(rs_rt), 32'd5);
    chk("ld_ra",     32'(ra), 32'd1);
    chk("ld_imm16",  32'(imm16), 32'h8);
    chk("ld_xods",   32'(xods), 32'd0);
    chk("ld_pc_out", pc_out, 32'h4);

    // backpressure in HOLD
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid",  32'(instr_valid), 32'd1);
      chk("bp_opcode", 32'(opcode), 32'd58);
      chk("bp_imm16",  32'(imm16), 32'h8);
      chk("bp_req",    32'(imem_req), 32'd0);
    end
    instr_ready = 1'b1;
    tick();
    chk("bp_rel_valid", 32'(instr_valid), 32'd0);
    chk("bp_rel_req",   32'(imem_req), 32'd1);
    chk("bp_rel_addr",  imem_addr, 32'h8);

    // redirect while a request is outstanding -> drain
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect_valid = 1'b0;
    chk("drn_req",  32'(imem_req), 32'd1);
    chk("drn_addr", imem_addr, 32'h8);
    tick();
    chk("drn_addr2", imem_addr, 32'h8);
    imem_ack = 1'b1; imem_rdata = 32'hDEADBEEF;
    tick();
    imem_ack = 1'b0;
    chk("drn_valid", 32'(instr_valid), 32'd0);
    chk("drn_req3",  32'(imem_req), 32'd1);
    chk("drn_new",   imem_addr, 32'h100);

    // redirect on the same cycle as the accept handshake
    imem_ack = 1'b1; imem_rdata = 32'h38200005;
    tick();
    imem_ack = 1'b0;
    chk("acc_valid",  32'(instr_valid), 32'd1);
    chk("acc_opcode", 32'(opcode), 32'd14);
    chk("acc_pc_out", pc_out, 32'h100);
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    tick();
    redirect_valid = 1'b0;
    chk("rdacc_valid", 32'(instr_valid), 32'd0);
    chk("rdacc_addr",  imem_addr, 32'h200);

    // redirect with ack the same cycle in REQ: data dropped
    redirect_valid = 1'b1; redirect_pc = 32'hFFFFFFFC;
    imem_ack = 1'b1; imem_rdata = 32'h12345678;
    tick();
    redirect_valid = 1'b0;
    chk("rdack_valid", 32'(instr_valid), 32'd0);
    chk("rdack_addr",  imem_addr, 32'hFFFFFFFC);

    // PC wrap, opcode 0 fetched
    imem_rdata = 32'h0; instr_ready = 1'b0;
    tick();
    imem_ack = 1'b0;
    chk("wrap_valid",   32'(instr_valid), 32'd1);
    chk("wrap_pc_out",  pc_out, 32'hFFFFFFFC);
    chk("wrap_opcode",  32'(opcode), 32'd0);
    chk("wrap_illegal", 32'(illegal_op), 32'(EXP_ILL));
    instr_ready = 1'b1;
    tick();
    chk("wrap_addr",     imem_addr, 32'h0);
    chk("wrap_ill_clr",  32'(illegal_op), 32'd0);

    // consecutive redirects while draining: last one wins
    redirect_valid = 1'b1; redirect_pc = 32'h300;
    tick();
    redirect_pc = 32'h400;
    tick();
    redirect_valid = 1'b0;
    chk("dd_addr", imem_addr, 32'h0);
    imem_ack = 1'b1; imem_rdata = 32'hCAFEF00D;
    tick();
    chk("dd_valid", 32'(instr_valid), 32'd0);
    chk("dd_addr2", imem_addr, 32'h400);
    imem_rdata = 32'h7C221A15;
    tick();
    imem_ack = 1'b0;
    chk("dd_pc_out", pc_out, 32'h400);
    chk("dd_lkrc",   32'(lk_rc), 32'd1);
    chk("dd_ill",    32'(illegal_op), 32'd0);
    tick();
    chk("dd_next", imem_addr, 32'h404);

    // asynchronous reset mid-transaction
    @(negedge clk) rst_n = 1'b0;
    #1;
    chk("mid_rst_req",   32'(imem_req), 32'd0);
    chk("mid_rst_pcout", pc_out, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk("mid_rel_req",  32'(imem_req), 32'd1);
    chk("mid_rel_addr", imem_addr, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
